// File: rtl/data_mem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package data_mem_arb_pkg;

    localparam int ADDR_W_DEF    = 14;
    localparam int DATA_W_DEF    = 16;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    // State literals carry an ST_ prefix so they do not collide with owner_t in this scope.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } state_t;

    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester A/B and RAM16K signal bundle; slave = arbiter side, master = requesters plus RAM.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = data_mem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = data_mem_arb_pkg::DATA_W_DEF
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_in;
    logic              ram_load;
    logic [DATA_W-1:0] ram_out;
    logic              busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  ram_out,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_address, ram_in, ram_load, busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output ram_out,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_address, ram_in, ram_load, busy
    );

endinterface

// File: rtl/data_mem_arb_pick.sv
// Combinational winner select. DMEM_ARB_ROUND_ROBIN_EN makes the IDLE tie-break alternate
// against last_owner; otherwise port A always wins an IDLE tie.
module data_mem_arb_pick
    import data_mem_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int CNT_W     = cnt_width(MAX_BURST_DEF)
) (
    input  state_t           state,
    input  logic [CNT_W-1:0] cnt,
    input  logic             a_req,
    input  logic             b_req,
    input  owner_t           last_owner,
    output owner_t           winner
);

    owner_t tie_winner;
    logic   burst_open;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    assign tie_winner = (last_owner == OWN_A) ? OWN_B : OWN_A;
`else
    logic unused_last_owner;
    assign unused_last_owner = ^last_owner;
    assign tie_winner        = OWN_A;
`endif

    // The current owner may keep going past MAX_BURST only while the other port is silent.
    assign burst_open = (cnt < CNT_W'(MAX_BURST));

    always_comb begin
        winner = OWN_NONE;
        case (state)
            ST_IDLE: begin
                if (a_req && b_req)  winner = tie_winner;
                else if (a_req)      winner = OWN_A;
                else if (b_req)      winner = OWN_B;
            end
            ST_OWN_A: begin
                if (a_req && (burst_open || !b_req)) winner = OWN_A;
                else if (b_req)                      winner = OWN_B;
            end
            ST_OWN_B: begin
                if (b_req && (burst_open || !a_req)) winner = OWN_B;
                else if (a_req)                      winner = OWN_A;
            end
            default: winner = OWN_NONE;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares single-port RAM16K between port A (CPU data) and port B (loader/DMA), one access per clock,
// 1-cycle read latency. Build with DMEM_ARB_ROUND_ROBIN_EN for alternating IDLE tie-break.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    data_mem_arbiter_if.slave  bus
);

    localparam int CNT_W = cnt_width(MAX_BURST);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
    owner_t            last_owner_reg;
    owner_t            winner;
    logic              a_rvalid_reg, b_rvalid_reg, busy_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              grant_a, grant_b, grant_any;
    logic              read_a, read_b;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic              load_mux;

    data_mem_arb_pick #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .state      (state_reg),
        .cnt        (cnt_reg),
        .a_req      (bus.a_req),
        .b_req      (bus.b_req),
        .last_owner (last_owner_reg),
        .winner     (winner)
    );

    // Grants are combinational, so they must be masked while reset is held.
    assign grant_a   = reset_n && (winner == OWN_A);
    assign grant_b   = reset_n && (winner == OWN_B);
    assign grant_any = grant_a || grant_b;
    assign read_a    = grant_a && !bus.a_we;
    assign read_b    = grant_b && !bus.b_we;
    assign cnt_inc   = (cnt_reg == CNT_W'(MAX_BURST)) ? cnt_reg : cnt_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (grant_a) begin
            state_next = ST_OWN_A;
            cnt_next   = (state_reg == ST_OWN_A) ? cnt_inc : CNT_W'(1);
        end else if (grant_b) begin
            state_next = ST_OWN_B;
            cnt_next   = (state_reg == ST_OWN_B) ? cnt_inc : CNT_W'(1);
        end else begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end
    end

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        load_mux  = 1'b0;
        if (grant_a) begin
            addr_mux  = bus.a_addr;
            wdata_mux = bus.a_wdata;
            load_mux  = bus.a_we;
        end else if (grant_b) begin
            addr_mux  = bus.b_addr;
            wdata_mux = bus.b_wdata;
            load_mux  = bus.b_we;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            last_owner_reg <= OWN_B;
            a_rvalid_reg   <= 1'b0;
            b_rvalid_reg   <= 1'b0;
            rdata_reg      <= '0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            a_rvalid_reg <= read_a;
            b_rvalid_reg <= read_b;
            busy_reg     <= (state_next != ST_IDLE);
            if (grant_any) begin
                last_owner_reg <= winner;
            end
            // Shared capture register: holds the last read until another read is granted.
            if (read_a || read_b) begin
                rdata_reg <= bus.ram_out;
            end
        end
    end

    assign bus.a_gnt       = grant_a;
    assign bus.b_gnt       = grant_b;
    assign bus.a_rvalid    = a_rvalid_reg;
    assign bus.b_rvalid    = b_rvalid_reg;
    assign bus.a_rdata     = rdata_reg;
    assign bus.b_rdata     = rdata_reg;
    assign bus.ram_address = addr_mux;
    assign bus.ram_in      = wdata_mux;
    assign bus.ram_load    = load_mux;
    assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: stimulus queues expected grants/reads, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_data_mem_arbiter;
    import data_mem_arb_pkg::*;

    typedef struct packed {
        owner_t      who;
        logic        we;
        logic [13:0] addr;
        logic [15:0] wdata;
    } gnt_exp_t;

    typedef struct packed {
        owner_t      who;
        logic [15:0] data;
    } rd_exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    gnt_exp_t gnt_q[$];
    rd_exp_t  rd_q[$];
    logic [15:0] mem [0:16383];

    data_mem_arbiter_if bus ();

    data_mem_arbiter #(
        .ADDR_W    (14),
        .DATA_W    (16),
        .MAX_BURST (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // RAM16K model: combinational read, write on rising edge when load is set.
    assign bus.ram_out = mem[bus.ram_address];
    always @(posedge clk) begin
        if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_rd(input owner_t who, input logic [15:0] data);
        rd_exp_t r;
        if (rd_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_rvalid: port %0d presented rdata 0x%0h with no read expected", who, data);
        end else begin
            r = rd_q.pop_front();
            check("rvalid_port", 32'(who), 32'(r.who));
            check("rdata", 32'(data), 32'(r.data));
            $display("t=%0t read  port=%0d rdata=0x%04h exp=0x%04h", $time, who, data, r.data);
        end
    endtask

    // Monitor
    always @(negedge clk) begin : monitor
        gnt_exp_t e;
        if (bus.a_gnt || bus.b_gnt) begin
            if (gnt_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_gnt: a_gnt=%0b b_gnt=%0b with no grant expected", bus.a_gnt, bus.b_gnt);
            end else begin
                e = gnt_q.pop_front();
                check("a_gnt", 32'(bus.a_gnt), 32'(e.who == OWN_A));
                check("b_gnt", 32'(bus.b_gnt), 32'(e.who == OWN_B));
                check("ram_address", 32'(bus.ram_address), 32'(e.addr));
                check("ram_load", 32'(bus.ram_load), 32'(e.we));
                if (e.we) check("ram_in", 32'(bus.ram_in), 32'(e.wdata));
                $display("t=%0t grant a=%0b b=%0b addr=0x%04h load=%0b in=0x%04h",
                         $time, bus.a_gnt, bus.b_gnt, bus.ram_address, bus.ram_load, bus.ram_in);
            end
        end else begin
            check("idle_bus", {bus.ram_load, bus.ram_address, bus.ram_in}, 32'd0);
        end
        if (bus.a_rvalid) check_rd(OWN_A, bus.a_rdata);
        if (bus.b_rvalid) check_rd(OWN_B, bus.b_rdata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [13:0] addr, input logic [15:0] wd);
        bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [13:0] addr, input logic [15:0] wd);
        bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    endtask

    task automatic exp_gnt(input owner_t who, input logic we, input logic [13:0] addr, input logic [15:0] wd);
        gnt_exp_t e;
        e.who = who; e.we = we; e.addr = addr; e.wdata = wd;
        gnt_q.push_back(e);
    endtask

    task automatic exp_rd(input owner_t who, input logic [15:0] data);
        rd_exp_t r;
        r.who = who; r.data = data;
        rd_q.push_back(r);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin : stimulus
        owner_t second_tie;
        set_a(1'b0, 1'b0, 14'h0, 16'h0);
        set_b(1'b0, 1'b0, 14'h0, 16'h0);

        // Reset held with both requesting: nothing may reach the RAM.
        set_a(1'b1, 1'b1, 14'h0010, 16'h1234);
        set_b(1'b1, 1'b0, 14'h0010, 16'h0000);
        tick(); tick();
        @(negedge clk); #1;
        check("rst_a_gnt", 32'(bus.a_gnt), 32'd0);
        check("rst_b_gnt", 32'(bus.b_gnt), 32'd0);
        check("rst_ram_load", 32'(bus.ram_load), 32'd0);
        check("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
        check("rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        // Release: A write wins first, then B reads the new value.
        tick();
        reset_n = 1'b1;
        exp_gnt(OWN_A, 1'b1, 14'h0010, 16'h1234);
        tick();
        set_a(1'b0, 1'b0, 14'h0, 16'h0);
        exp_gnt(OWN_B, 1'b0, 14'h0010, 16'h0);
        exp_rd(OWN_B, 16'h1234);
        tick();
        set_b(1'b0, 1'b0, 14'h0, 16'h0);
        tick();
        check("busy_after_idle", 32'(bus.busy), 32'd0);

        // Both continuously requesting: bursts of MAX_BURST alternate.
        set_a(1'b1, 1'b1, 14'h0100, 16'hA001);
        set_b(1'b1, 1'b1, 14'h0200, 16'hB002);
        for (int i = 0; i < 12; i++) begin
            if (i >= 4 && i < 8) exp_gnt(OWN_B, 1'b1, 14'h0200, 16'hB002);
            else                 exp_gnt(OWN_A, 1'b1, 14'h0100, 16'hA001);
            tick();
        end
        set_a(1'b0, 1'b0, 14'h0, 16'h0);
        set_b(1'b0, 1'b0, 14'h0, 16'h0);
        tick(); tick();

        // Make B the last owner, then two IDLE ties separated by an idle gap.
        set_b(1'b1, 1'b1, 14'h0300, 16'h5555);
        exp_gnt(OWN_B, 1'b1, 14'h0300, 16'h5555);
        tick();
        set_b(1'b0, 1'b0, 14'h0, 16'h0);
        tick();
        set_a(1'b1, 1'b1, 14'h0400, 16'h0A0A);
        set_b(1'b1, 1'b1, 14'h0401, 16'h0B0B);
        exp_gnt(OWN_A, 1'b1, 14'h0400, 16'h0A0A);
        tick();
        set_a(1'b0, 1'b0, 14'h0, 16'h0);
        set_b(1'b0, 1'b0, 14'h0, 16'h0);
        tick(); tick();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        second_tie = OWN_B;
`else
        second_tie = OWN_A;
`endif
        set_a(1'b1, 1'b1, 14'h0400, 16'h0A0A);
        set_b(1'b1, 1'b1, 14'h0401, 16'h0B0B);
        if (second_tie == OWN_A) exp_gnt(OWN_A, 1'b1, 14'h0400, 16'h0A0A);
        else                     exp_gnt(OWN_B, 1'b1, 14'h0401, 16'h0B0B);
        tick();
        set_a(1'b0, 1'b0, 14'h0, 16'h0);
        set_b(1'b0, 1'b0, 14'h0, 16'h0);
        tick(); tick();

        // Cross-port write then read on consecutive grants.
        set_b(1'b1, 1'b1, 14'h0020, 16'h7777);
        exp_gnt(OWN_B, 1'b1, 14'h0020, 16'h7777);
        tick();
        set_b(1'b0, 1'b0, 14'h0, 16'h0);
        set_a(1'b1, 1'b0, 14'h0020, 16'h0);
        exp_gnt(OWN_A, 1'b0, 14'h0020, 16'h0);
        exp_rd(OWN_A, 16'h7777);
        tick();
        set_a(1'b0, 1'b0, 14'h0, 16'h0);
        tick(); tick();

        // Top address write then read, then drop to IDLE.
        set_a(1'b1, 1'b1, 14'h3FFF, 16'hBEEF);
        exp_gnt(OWN_A, 1'b1, 14'h3FFF, 16'hBEEF);
        tick();
        set_a(1'b1, 1'b0, 14'h3FFF, 16'h0);
        exp_gnt(OWN_A, 1'b0, 14'h3FFF, 16'h0);
        exp_rd(OWN_A, 16'hBEEF);
        tick();
        set_a(1'b0, 1'b0, 14'h0, 16'h0);
        check("busy_owning", 32'(bus.busy), 32'd1);
        tick();
        check("busy_released", 32'(bus.busy), 32'd0);
        tick();

        // Reset pulse across a B read grant: the read is lost, reissue succeeds.
        set_b(1'b1, 1'b0, 14'h0010, 16'h0);
        exp_gnt(OWN_B, 1'b0, 14'h0010, 16'h0);
        @(negedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("pulse_b_rvalid", 32'(bus.b_rvalid), 32'd0);
        check("pulse_busy", 32'(bus.busy), 32'd0);
        check("pulse_b_gnt", 32'(bus.b_gnt), 32'd0);
        reset_n = 1'b1;
        exp_gnt(OWN_B, 1'b0, 14'h0010, 16'h0);
        exp_rd(OWN_B, 16'h1234);
        tick();
        set_b(1'b0, 1'b0, 14'h0, 16'h0);
        tick(); tick(); tick();

        check("gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
